// File: rtl/paddle_pkg.sv
// Shared types and defaults for the paddle motion controller.
package paddle_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEL  = 2'd1,
    CRUISE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_INC  = 2'd1,
    DIR_DEC  = 2'd2
  } dir_t;

  localparam int POS_W_DEF     = 12;
  localparam int SPEED_MAX_DEF = 4;

  // Width of a speed value able to hold 0..smax.
  function automatic int speed_w(input int smax);
    return $clog2(smax + 1);
  endfunction

endpackage

// File: rtl/paddle_axis_if.sv
// Control inputs and bounding-box outputs of one paddle axis.
// Tracking ports exist only when PADDLE_AI_EN is defined.
interface paddle_axis_if #(
  parameter int POS_W = paddle_pkg::POS_W_DEF,
  parameter int SPD_W = paddle_pkg::speed_w(paddle_pkg::SPEED_MAX_DEF)
);
  logic             i_ani_stb;
  logic             i_animate;
  logic             i_inc_btn;
  logic             i_dec_btn;
`ifdef PADDLE_AI_EN
  logic             i_ai_mode;
  logic [POS_W-1:0] i_target_x;
`endif
  logic [POS_W-1:0] o_x1;
  logic [POS_W-1:0] o_x2;
  logic [POS_W-1:0] o_y1;
  logic [POS_W-1:0] o_y2;
  logic [SPD_W-1:0] o_speed;
  logic             o_at_limit;

`ifdef PADDLE_AI_EN
  modport master (
    output i_ani_stb, i_animate, i_inc_btn, i_dec_btn, i_ai_mode, i_target_x,
    input  o_x1, o_x2, o_y1, o_y2, o_speed, o_at_limit
  );
  modport slave (
    input  i_ani_stb, i_animate, i_inc_btn, i_dec_btn, i_ai_mode, i_target_x,
    output o_x1, o_x2, o_y1, o_y2, o_speed, o_at_limit
  );
`else
  modport master (
    output i_ani_stb, i_animate, i_inc_btn, i_dec_btn,
    input  o_x1, o_x2, o_y1, o_y2, o_speed, o_at_limit
  );
  modport slave (
    input  i_ani_stb, i_animate, i_inc_btn, i_dec_btn,
    output o_x1, o_x2, o_y1, o_y2, o_speed, o_at_limit
  );
`endif

endinterface

// File: rtl/paddle_accel.sv
// Speed ramp FSM: tracks held direction, frame counter and current speed,
// and tells the parent how far to move on this update strobe.
module paddle_accel
  import paddle_pkg::*;
#(
  parameter int SPEED_MAX    = 4,
  parameter int ACCEL_FRAMES = 8,
  parameter int SPD_W        = $clog2(SPEED_MAX + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             upd,
  input  dir_t             dir,
  input  logic             stop,
  output logic [SPD_W-1:0] step,
  output logic [SPD_W-1:0] speed,
  output state_t           state
);

  localparam int                CNT_W       = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(ACCEL_FRAMES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [SPD_W-1:0]  SPD_ONE     = SPD_W'(1);
  localparam logic [SPD_W-1:0]  SPD_TOP     = SPD_W'(SPEED_MAX);
  localparam state_t            START_STATE = (SPEED_MAX == 1) ? CRUISE : ACCEL;

  state_t           state_reg;
  dir_t             dir_q_reg;
  logic [SPD_W-1:0] speed_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             fresh;
  logic             ramp;
  logic [SPD_W-1:0] speed_up;

  // A ramp step takes effect on the strobe that completes the frame count,
  // so every speed level is used for exactly ACCEL_FRAMES strobes.
  always_comb begin
    fresh    = (state_reg == IDLE) || (dir != dir_q_reg);
    ramp     = (state_reg == ACCEL) && (cnt_reg == CNT_LAST);
    speed_up = speed_reg + SPD_ONE;
    step     = '0;
    if (dir != DIR_NONE) begin
      if (fresh) begin
        step = SPD_ONE;
      end else if (ramp) begin
        step = speed_up;
      end else begin
        step = speed_reg;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      dir_q_reg <= DIR_NONE;
      speed_reg <= '0;
      cnt_reg   <= '0;
    end else if (upd) begin
      if ((dir == DIR_NONE) || stop) begin
        state_reg <= IDLE;
        speed_reg <= '0;
        cnt_reg   <= '0;
      end else if (fresh) begin
        state_reg <= START_STATE;
        dir_q_reg <= dir;
        speed_reg <= SPD_ONE;
        cnt_reg   <= '0;
      end else if (state_reg == ACCEL) begin
        if (ramp) begin
          cnt_reg   <= '0;
          speed_reg <= speed_up;
          if (speed_up == SPD_TOP) begin
            state_reg <= CRUISE;
          end
        end else begin
          cnt_reg <= cnt_reg + CNT_ONE;
        end
      end
    end
  end

  assign speed = speed_reg;
  assign state = state_reg;

endmodule

// File: rtl/paddle_axis.sv
// Horizontal paddle controller: direction decode, clamped position and
// bounding box. Define PADDLE_AI_EN to add the target-tracking mode.
module paddle_axis
  import paddle_pkg::*;
#(
  parameter int POS_W        = POS_W_DEF,
  parameter int H_SIZE       = 80,
  parameter int V_SIZE       = 30,
  parameter int IX           = 320,
  parameter int IY           = 240,
  parameter int X_MIN        = 80,
  parameter int X_MAX        = 600,
  parameter int SPEED_MAX    = SPEED_MAX_DEF,
  parameter int ACCEL_FRAMES = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  paddle_axis_if.slave  bus
);

  localparam int               SPD_W     = speed_w(SPEED_MAX);
  localparam logic [POS_W-1:0] X_RST     = POS_W'(IX);
  localparam logic [POS_W-1:0] X_MIN_P   = POS_W'(X_MIN);
  localparam logic [POS_W-1:0] X_MAX_P   = POS_W'(X_MAX);
  localparam logic [POS_W:0]   X_MIN_E   = (POS_W + 1)'(X_MIN);
  localparam logic [POS_W:0]   X_MAX_E   = (POS_W + 1)'(X_MAX);
  localparam logic [POS_W-1:0] H_SIZE_P  = POS_W'(H_SIZE);
  localparam logic             LIM_RST   = (IX == X_MIN) || (IX == X_MAX);

  logic [POS_W-1:0] x_reg;
  logic             at_limit_reg;

  logic             upd_stb;
  dir_t             dir;
  logic [SPD_W-1:0] step;
  logic [SPD_W-1:0] speed;
  state_t           accel_state;

  logic [POS_W:0]   x_ext;
  logic [POS_W:0]   step_ext;
  logic [POS_W:0]   sum_ext;
  logic [POS_W:0]   diff_ext;
  logic [POS_W:0]   floor_ext;
  logic [POS_W-1:0] x_next;
  logic             hit;

  assign upd_stb = bus.i_animate & bus.i_ani_stb;
  assign x_ext   = {1'b0, x_reg};

`ifdef PADDLE_AI_EN
  localparam logic [POS_W:0] SMAX_E = (POS_W + 1)'(SPEED_MAX);
  logic [POS_W:0] tgt_ext;
  assign tgt_ext = {1'b0, bus.i_target_x};
`endif

  always_comb begin
    dir = DIR_NONE;
    if (bus.i_inc_btn && !bus.i_dec_btn) begin
      dir = DIR_INC;
    end else if (bus.i_dec_btn && !bus.i_inc_btn) begin
      dir = DIR_DEC;
    end
`ifdef PADDLE_AI_EN
    // Deadband of +-SPEED_MAX around the target stops the paddle hunting.
    if (bus.i_ai_mode) begin
      dir = DIR_NONE;
      if (tgt_ext > x_ext + SMAX_E) begin
        dir = DIR_INC;
      end else if (tgt_ext + SMAX_E < x_ext) begin
        dir = DIR_DEC;
      end
    end
`endif
  end

  paddle_accel #(
    .SPEED_MAX    (SPEED_MAX),
    .ACCEL_FRAMES (ACCEL_FRAMES),
    .SPD_W        (SPD_W)
  ) u_accel (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .upd   (upd_stb),
    .dir   (dir),
    .stop  (hit),
    .step  (step),
    .speed (speed),
    .state (accel_state)
  );

  // One extra bit keeps x+step and X_MIN+step from wrapping; step >= 1
  // also flags a paddle already parked on the wall it is pushed into.
  always_comb begin
    step_ext  = (POS_W + 1)'(step);
    sum_ext   = x_ext + step_ext;
    diff_ext  = x_ext - step_ext;
    floor_ext = X_MIN_E + step_ext;
    x_next    = x_reg;
    hit       = 1'b0;
    case (dir)
      DIR_INC: begin
        if (sum_ext > X_MAX_E) begin
          x_next = X_MAX_P;
          hit    = 1'b1;
        end else begin
          x_next = sum_ext[POS_W-1:0];
        end
      end
      DIR_DEC: begin
        if (x_ext < floor_ext) begin
          x_next = X_MIN_P;
          hit    = 1'b1;
        end else begin
          x_next = diff_ext[POS_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_reg        <= X_RST;
      at_limit_reg <= LIM_RST;
    end else if (upd_stb) begin
      x_reg        <= x_next;
      at_limit_reg <= (x_next == X_MIN_P) || (x_next == X_MAX_P);
    end
  end

  assign bus.o_x1       = x_reg - H_SIZE_P;
  assign bus.o_x2       = x_reg + H_SIZE_P;
  assign bus.o_y1       = POS_W'(IY - V_SIZE);
  assign bus.o_y2       = POS_W'(IY + V_SIZE);
  assign bus.o_speed    = (accel_state == IDLE) ? '0 : speed;
  assign bus.o_at_limit = at_limit_reg;

endmodule
